// File: rtl/tlb_entry_array.sv
// Fully-associative TLB entry array: single-cycle CAM lookup with registered response, refill, flush.
// Build option TLB_FREE_FIRST_EN: refills without a VPN match go to the lowest free entry before the policy victim.
module tlb_entry_array #(
  parameter int ENTRIES = 8,
  parameter int VPN_W   = 27,
  parameter int PPN_W   = 44
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       lookup_valid_i,
  input  logic [VPN_W-1:0]           lookup_vpn_i,
  output logic                       lookup_ready_o,
  output logic                       resp_valid_o,
  output logic                       resp_hit_o,
  output logic [PPN_W-1:0]           resp_ppn_o,
  output logic [$clog2(ENTRIES)-1:0] resp_idx_o,
  input  logic                       refill_valid_i,
  input  logic [VPN_W-1:0]           refill_vpn_i,
  input  logic [PPN_W-1:0]           refill_ppn_i,
  output logic                       refill_ready_o,
  input  logic                       flush_i,
  output logic                       plru_hit_o,
  output logic [$clog2(ENTRIES)-1:0] plru_idx_o,
  input  logic [$clog2(ENTRIES)-1:0] replacement_idx_i
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [VPN_W-1:0]   vpn_q [ENTRIES];
  logic [PPN_W-1:0]   ppn_q [ENTRIES];

  logic               ready;
  logic               lookup_fire;
  logic               refill_fire;
  logic               lk_hit;
  logic [IDX_W-1:0]   lk_idx;
  logic [PPN_W-1:0]   lk_ppn;
  logic               rf_hit;
  logic [IDX_W-1:0]   rf_idx;
  logic [IDX_W-1:0]   wr_idx;

  logic               resp_valid_q, resp_hit_q;
  logic [PPN_W-1:0]   resp_ppn_q;
  logic [IDX_W-1:0]   resp_idx_q;

  assign ready       = (state_q == RUN) && !flush_i;
  assign lookup_fire = lookup_valid_i && ready;
  assign refill_fire = refill_valid_i && ready;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    lk_ppn = '0;
    rf_hit = 1'b0;
    rf_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (vpn_q[i] == lookup_vpn_i)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
        lk_ppn = ppn_q[i];
      end
      if (valid_q[i] && (vpn_q[i] == refill_vpn_i)) begin
        rf_hit = 1'b1;
        rf_idx = IDX_W'(i);
      end
    end
  end

`ifdef TLB_FREE_FIRST_EN
  logic             free_vld;
  logic [IDX_W-1:0] free_idx;

  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign wr_idx = rf_hit ? rf_idx : (free_vld ? free_idx : replacement_idx_i);
`else
  assign wr_idx = rf_hit ? rf_idx : replacement_idx_i;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    case (state_q)
      RUN: begin
        if (flush_i) begin
          valid_d = '0;
          state_d = FLUSH;
        end else if (refill_fire) begin
          valid_d[wr_idx] = 1'b1;
        end
      end
      FLUSH: begin
        if (flush_i) valid_d = '0;
        else         state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= RUN;
      valid_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_ppn_q   <= '0;
      resp_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      resp_valid_q <= lookup_fire;
      resp_hit_q   <= lookup_fire && lk_hit;
      resp_ppn_q   <= lookup_fire ? lk_ppn : '0;
      resp_idx_q   <= lookup_fire ? lk_idx : '0;
    end
  end

  // Payload storage carries no reset; valid bits alone qualify it.
  always_ff @(posedge clk_i) begin
    if (refill_fire) begin
      vpn_q[wr_idx] <= refill_vpn_i;
      ppn_q[wr_idx] <= refill_ppn_i;
    end
  end

  assign lookup_ready_o = ready;
  assign refill_ready_o = ready;
  assign resp_valid_o   = resp_valid_q;
  assign resp_hit_o     = resp_hit_q;
  assign resp_ppn_o     = resp_ppn_q;
  assign resp_idx_o     = resp_idx_q;
  assign plru_hit_o     = resp_valid_q && resp_hit_q;
  assign plru_idx_o     = resp_idx_q;

endmodule

// File: tb/tb_tlb_entry_array.sv
// Scoreboard bench for tlb_entry_array: directed lookups/refills/flushes, monitor checks every response.
module tb_tlb_entry_array;

`ifdef TLB_FREE_FIRST_EN
  localparam bit FF = 1'b1;
`else
  localparam bit FF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        lookup_valid_i = 1'b0;
  logic [26:0] lookup_vpn_i = '0;
  logic        lookup_ready_o;
  logic        resp_valid_o;
  logic        resp_hit_o;
  logic [43:0] resp_ppn_o;
  logic [2:0]  resp_idx_o;
  logic        refill_valid_i = 1'b0;
  logic [26:0] refill_vpn_i = '0;
  logic [43:0] refill_ppn_i = '0;
  logic        refill_ready_o;
  logic        flush_i = 1'b0;
  logic        plru_hit_o;
  logic [2:0]  plru_idx_o;
  logic [2:0]  replacement_idx_i = '0;

  tlb_entry_array dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .lookup_valid_i(lookup_valid_i), .lookup_vpn_i(lookup_vpn_i), .lookup_ready_o(lookup_ready_o),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_ppn_o(resp_ppn_o), .resp_idx_o(resp_idx_o),
    .refill_valid_i(refill_valid_i), .refill_vpn_i(refill_vpn_i), .refill_ppn_i(refill_ppn_i),
    .refill_ready_o(refill_ready_o), .flush_i(flush_i),
    .plru_hit_o(plru_hit_o), .plru_idx_o(plru_idx_o), .replacement_idx_i(replacement_idx_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        hit;
    logic [43:0] ppn;
    logic [2:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response pops one expectation.
  always @(negedge clk_i) begin
    if (resp_valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'(resp_valid_o), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_hit",  64'(resp_hit_o), 64'(e.hit));
        check("resp_ppn",  64'(resp_ppn_o), 64'(e.ppn));
        check("resp_idx",  64'(resp_idx_o), 64'(e.idx));
        check("plru_hit",  64'(plru_hit_o), 64'(e.hit));
        check("plru_idx",  64'(plru_idx_o), 64'(e.idx));
      end
    end else begin
      check("plru_idle", 64'(plru_hit_o), 64'd0);
    end
  end

  task automatic push(input logic hit, input logic [43:0] ppn, input logic [2:0] idx);
    exp_t e;
    e.hit = hit; e.ppn = ppn; e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic lookup(input logic [26:0] vpn, input logic hit, input logic [43:0] ppn,
                        input logic [2:0] idx);
    @(posedge clk_i); #1;
    lookup_valid_i = 1'b1;
    lookup_vpn_i   = vpn;
    check("lookup_ready", 64'(lookup_ready_o), 64'd1);
    push(hit, ppn, idx);
    @(posedge clk_i); #1;
    lookup_valid_i = 1'b0;
    @(negedge clk_i); #1;
    check("resp_latency", 64'(sb.size()), 64'd0);
  endtask

  task automatic refill(input logic [26:0] vpn, input logic [43:0] ppn, input logic [2:0] repl);
    @(posedge clk_i); #1;
    refill_valid_i    = 1'b1;
    refill_vpn_i      = vpn;
    refill_ppn_i      = ppn;
    replacement_idx_i = repl;
    check("refill_ready", 64'(refill_ready_o), 64'd1);
    @(posedge clk_i); #1;
    refill_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    check("rst_resp_hit",   64'(resp_hit_o),   64'd0);
    check("rst_resp_ppn",   64'(resp_ppn_o),   64'd0);
    check("rst_resp_idx",   64'(resp_idx_o),   64'd0);
    check("rst_plru_idx",   64'(plru_idx_o),   64'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("rst_ready", 64'(lookup_ready_o), 64'd1);

    // Empty array misses
    lookup(27'h123, 1'b0, 44'h0, 3'd0);

    // Refill and hit
    refill(27'h0B2, 44'hB22, 3'd2);
    refill(27'h123, 44'h456, 3'd5);
    lookup(27'h123, 1'b1, 44'h456, FF ? 3'd1 : 3'd5);

    // Matching refill overwrites in place; other entry untouched
    refill(27'h123, 44'h789, 3'd2);
    lookup(27'h123, 1'b1, 44'h789, FF ? 3'd1 : 3'd5);
    lookup(27'h0B2, 1'b1, 44'hB22, FF ? 3'd0 : 3'd2);

    // Lookup just before flush sees pre-flush contents; ready drops for flush + FLUSH cycles
    @(posedge clk_i); #1;
    lookup_valid_i = 1'b1;
    lookup_vpn_i   = 27'h123;
    push(1'b1, 44'h789, FF ? 3'd1 : 3'd5);
    @(posedge clk_i); #1;
    lookup_valid_i = 1'b0;
    flush_i        = 1'b1;
    @(negedge clk_i);
    check("flush_cycle_ready", 64'(lookup_ready_o), 64'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_state_ready", 64'(refill_ready_o), 64'd0);
    @(negedge clk_i);
    check("post_flush_ready", 64'(lookup_ready_o), 64'd1);
    lookup(27'h123, 1'b0, 44'h0, 3'd0);
    lookup(27'h0B2, 1'b0, 44'h0, 3'd0);

    // Same-cycle lookup and refill: response from pre-write contents
    @(posedge clk_i); #1;
    lookup_valid_i    = 1'b1;
    lookup_vpn_i      = 27'h0AA;
    refill_valid_i    = 1'b1;
    refill_vpn_i      = 27'h0AA;
    refill_ppn_i      = 44'h0AB;
    replacement_idx_i = 3'd3;
    push(1'b0, 44'h0, 3'd0);
    @(posedge clk_i); #1;
    lookup_valid_i = 1'b0;
    refill_valid_i = 1'b0;
    lookup(27'h0AA, 1'b1, 44'h0AB, FF ? 3'd0 : 3'd3);

    // Reset during an accepted lookup aborts the response
    @(posedge clk_i); #1;
    lookup_valid_i = 1'b1;
    lookup_vpn_i   = 27'h0AA;
    #2 rstn_i = 1'b0;
    #1 lookup_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("no_resp_after_reset", 64'(resp_valid_o), 64'd0);
    end
    lookup(27'h0AA, 1'b0, 44'h0, 3'd0);

    // Nine refills with a fixed victim of 6
    for (int k = 0; k < 9; k++) refill(27'h200 + 27'(k), 44'h300 + 44'(k), 3'd6);
    for (int k = 0; k < 8; k++) begin
      if (FF && k != 6) lookup(27'h200 + 27'(k), 1'b1, 44'h300 + 44'(k), 3'(k));
      else              lookup(27'h200 + 27'(k), 1'b0, 44'h0, 3'd0);
    end
    lookup(27'h208, 1'b1, 44'h308, 3'd6);

    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
